// File: rtl/aes_round.sv
// aes_round: one registered AES-128 encryption round.
//   SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, result registered.
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears roundout to all zero
//   roundin  : input state, 4x4 bytes, port[3-r][3-c] holds AES byte s[r][c]
//   key      : round key, same byte mapping as roundin
//   roundout : registered next state, same byte mapping, 1 cycle latency
//
// Build option
//   AES_ROUND_MIXCOLUMNS_EN : when defined, MixColumns is in the path (middle
//   round). When undefined, ShiftRows feeds AddRoundKey directly (final round).
//   Latency, reset and interface are identical in both builds.

module aes_round (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0][3:0][7:0]   roundin,
    input  logic [3:0][3:0][7:0]   key,
    output logic [3:0][3:0][7:0]   roundout
);

    // Forward S-box, byte 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        // entry x lives at byte position 255-x, and 255-x == ~x
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xt2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] xt3(input logic [7:0] x);
        return xt2(x) ^ x;
    endfunction

    // Internal arrays are held in AES coordinates: [r][c] = row r, column c.
    logic [3:0][3:0][7:0] t;    // after SubBytes + ShiftRows
    logic [3:0][3:0][7:0] m;    // after MixColumns (or bypass)
    logic [3:0][3:0][7:0] nxt;  // after AddRoundKey, port coordinates

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            // row r rotates left by r: t[r][c] = sb[r][(c+r)%4]
            assign t[r][c] = sbox(roundin[3-r][3-((c+r)%4)]);
            assign nxt[3-r][3-c] = m[r][c] ^ key[3-r][3-c];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
`ifdef AES_ROUND_MIXCOLUMNS_EN
        assign m[0][c] = xt2(t[0][c]) ^ xt3(t[1][c]) ^ t[2][c]      ^ t[3][c];
        assign m[1][c] = t[0][c]      ^ xt2(t[1][c]) ^ xt3(t[2][c]) ^ t[3][c];
        assign m[2][c] = t[0][c]      ^ t[1][c]      ^ xt2(t[2][c]) ^ xt3(t[3][c]);
        assign m[3][c] = xt3(t[0][c]) ^ t[1][c]      ^ t[2][c]      ^ xt2(t[3][c]);
`else
        assign m[0][c] = t[0][c];
        assign m[1][c] = t[1][c];
        assign m[2][c] = t[2][c];
        assign m[3][c] = t[3][c];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) roundout <= '0;
        else     roundout <= nxt;
    end

endmodule

// File: tb/tb_aes_round.sv
module tb_aes_round;

    typedef logic [3:0][3:0][7:0] st_t;

    logic clk = 1'b0;
    logic rst;
    st_t  roundin, key, roundout;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    aes_round dut (
        .clk      (clk),
        .rst      (rst),
        .roundin  (roundin),
        .key      (key),
        .roundout (roundout)
    );

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, xb;
            xb  = 8'(x);
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int i = 0; i < 254; i++) inv = gmul(inv, xb);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic st_t model(input st_t din, input st_t k);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] m [4][4];
        logic [7:0] coef [4];
        st_t o;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = sbox_t[din[3-r][3-c]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c + r) % 4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
`ifdef AES_ROUND_MIXCOLUMNS_EN
                m[r][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    m[r][c] = m[r][c] ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
`else
                m[r][c] = t[r][c];
`endif
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[3-r][3-c] = m[r][c] ^ k[3-r][3-c];
        return o;
    endfunction

    // FIPS-197 byte stream (byte 0 first) to port layout
    function automatic st_t from_fips(input logic [127:0] v);
        st_t p;
        for (int k = 0; k < 16; k++)
            p[3-(k%4)][3-(k/4)] = v[127-8*k -: 8];
        return p;
    endfunction

    function automatic st_t rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam st_t DISP_IN  = {32'h12637477, 32'h1b7a6205, 32'h19120d64, 32'h04791558};
    localparam st_t DISP_KEY = {32'he1c1e1c1, 32'h21105219, 32'h8664fdb8, 32'hf2ca9ec7};

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; roundin = rnd_state(); key = rnd_state();
        tick();
        vectors++;
        if (roundout !== '0) begin
            miscompares++;
            $display("FAIL reset: got %h expected all zero", roundout);
        end
    endtask

    task automatic test_display();
        st_t exp;
        rst = 1'b0; roundin = DISP_IN; key = DISP_KEY;
        exp = model(DISP_IN, DISP_KEY);
        tick();
        vectors++;
        if (roundout !== exp) begin
            miscompares++;
            $display("FAIL display_model: got %h expected %h", roundout, exp);
        end
`ifdef AES_ROUND_MIXCOLUMNS_EN
        begin
            logic [7:0] want [6];
            logic [7:0] got  [6];
            want = '{8'ha0, 8'h4a, 8'h93, 8'hc7, 8'h76, 8'h17};
            got  = '{roundout[3][3], roundout[3][0], roundout[2][2],
                     roundout[2][1], roundout[1][1], roundout[0][0]};
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got[i] !== want[i]) begin
                    miscompares++;
                    $display("FAIL display_byte%0d: got %h expected %h", i, got[i], want[i]);
                end
            end
        end
`endif
    endtask

    task automatic test_constants();
        st_t exp;
        rst = 1'b0; roundin = '0; key = '0;
        exp = {16{8'h63}};
        tick();
        vectors++;
        if (roundout !== exp) begin
            miscompares++;
            $display("FAIL const_zero_key: got %h expected %h", roundout, exp);
        end
        key = '1;
        exp = {16{8'h9c}};
        tick();
        vectors++;
        if (roundout !== exp) begin
            miscompares++;
            $display("FAIL const_ff_key: got %h expected %h", roundout, exp);
        end
    endtask

`ifdef AES_ROUND_MIXCOLUMNS_EN
    task automatic test_fips();
        st_t exp;
        rst = 1'b0;
        roundin = from_fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        key     = from_fips(128'ha0fafe1788542cb123a339392a6c7605);
        exp     = from_fips(128'ha49c7ff2689f352b6b5bea43026a5049);
        tick();
        vectors++;
        if (roundout !== exp) begin
            miscompares++;
            $display("FAIL fips_round1: got %h expected %h", roundout, exp);
        end
    endtask
`endif

    task automatic test_back_to_back();
        st_t exp0, exp1;
        exp0 = {16{8'h63}};
        exp1 = model(DISP_IN, DISP_KEY);
        rst = 1'b0; roundin = '0; key = '0;
        tick();
        // drive the next vector before looking, the output must still show the old one
        roundin = DISP_IN; key = DISP_KEY;
        vectors++;
        if (roundout !== exp0) begin
            miscompares++;
            $display("FAIL b2b_first: got %h expected %h", roundout, exp0);
        end
        tick();
        vectors++;
        if (roundout !== exp1) begin
            miscompares++;
            $display("FAIL b2b_second: got %h expected %h", roundout, exp1);
        end
    endtask

    task automatic test_reset_priority();
        st_t a, k;
        a = rnd_state(); k = rnd_state();
        rst = 1'b1; roundin = a; key = k;
        tick();
        vectors++;
        if (roundout !== '0) begin
            miscompares++;
            $display("FAIL rst_priority: got %h expected all zero", roundout);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (roundout !== model(a, k)) begin
            miscompares++;
            $display("FAIL rst_release: got %h expected %h", roundout, model(a, k));
        end
    endtask

    task automatic test_random();
        st_t exp;
        for (int i = 0; i < 300; i++) begin
            rst     = ($urandom_range(0, 19) == 0);
            roundin = rnd_state();
            key     = rnd_state();
            exp     = rst ? st_t'('0) : model(roundin, key);
            // a mid-cycle glitch that is undone before the edge must not matter
            #2 roundin = ~roundin;
            #1 roundin = ~roundin;
            tick();
            vectors++;
            if (roundout !== exp) begin
                miscompares++;
                $display("FAIL random%0d: got %h expected %h", i, roundout, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; roundin = '0; key = '0;
        build_sbox();
        @(negedge clk);
        test_reset();
        test_display();
        test_constants();
`ifdef AES_ROUND_MIXCOLUMNS_EN
        test_fips();
`endif
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
